// File: rtl/rx_pack_fifo_pkg.sv
// -----------------------------------------------------------------------------
// rx_pack_fifo_pkg
// Shared constants and helpers for the receive byte-packing FIFO.
//   BYTE_W      : width of one received byte lane (8)
//   pack_cnt_w(): width of the packer byte counter for a given word width,
//                 wide enough to hold 0..BYTES
// -----------------------------------------------------------------------------
package rx_pack_fifo_pkg;

  localparam int BYTE_W = 8;

  function automatic int pack_cnt_w(input int width);
    return $clog2(width / BYTE_W) + 1;
  endfunction

endpackage

// File: rtl/rx_byte_packer.sv
// -----------------------------------------------------------------------------
// rx_byte_packer
// Assembles accepted bytes into little-endian words. The word being closed
// (full word or byte_last_i) is presented combinationally with push_o in the
// same cycle as the closing byte, so the FIFO writes it on that edge.
//
// Ports
//   clk, resetn    : clock, async active-low reset
//   flush_i        : synchronous clear of count and partial word
//   byte_acc_i     : byte accepted this cycle (valid && ready, qualified above)
//   byte_data_i    : accepted byte
//   byte_last_i    : close the partial word after this byte
//   word_o         : word to store (unfilled lanes zero)
//   push_o         : word_o is to be written this cycle
//   pack_cnt_o     : bytes currently held
// -----------------------------------------------------------------------------
module rx_byte_packer
  import rx_pack_fifo_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          flush_i,
  input  logic                          byte_acc_i,
  input  logic [BYTE_W-1:0]             byte_data_i,
  input  logic                          byte_last_i,
  output logic [WIDTH-1:0]              word_o,
  output logic                          push_o,
  output logic [pack_cnt_w(WIDTH)-1:0]  pack_cnt_o
);

  localparam int BYTES = WIDTH / BYTE_W;
  localparam int CW    = pack_cnt_w(WIDTH);

  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] merged;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             word_done;

  // Current partial word with the incoming byte dropped into lane cnt_q.
  // Lanes above cnt_q are still zero because data_q is cleared on every push.
  always_comb begin
    merged = data_q;
    for (int i = 0; i < BYTES; i++) begin
      if (cnt_q == CW'(i)) begin
        merged[i*BYTE_W +: BYTE_W] = byte_data_i;
      end
    end
  end

  assign word_done = byte_acc_i && (byte_last_i || (cnt_q == CW'(BYTES - 1)));

  always_comb begin
    data_d = data_q;
    cnt_d  = cnt_q;
    if (flush_i || word_done) begin
      data_d = '0;
      cnt_d  = '0;
    end else if (byte_acc_i) begin
      data_d = merged;
      cnt_d  = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

  assign word_o     = merged;
  assign push_o     = word_done;
  assign pack_cnt_o = cnt_q;

endmodule

// File: rtl/rx_pack_fifo.sv
// -----------------------------------------------------------------------------
// rx_pack_fifo
// Receive path: bytes are packed little-endian into WIDTH-bit words by
// rx_byte_packer and stored in a DEPTH-entry FIFO. Read side is either
// first-word-fall-through (FWFT=1) or registered with one-cycle latency.
//
// Ports
//   clk, resetn        : clock, async active-low reset
//   flush_i            : synchronous clear of FIFO, packer and rd_valid_o
//   byte_valid_i/_data_i/_last_i, byte_ready_o : byte input handshake
//   rd_en_i            : pop request
//   rd_data_o          : read word (head when FWFT=1, registered when FWFT=0)
//   rd_valid_o         : rd_data_o valid
//   empty_o, full_o    : occupancy flags
//   level_o            : stored word count, 0..DEPTH
//   pack_cnt_o         : bytes held in the packer
//   watermark_i, wm_o  : wm_o = level_o >= watermark_i
//   ovf_o, udf_o       : sticky dropped-byte / empty-pop flags
//   err_clr_i          : clears ovf_o/udf_o (a same-cycle set wins)
// -----------------------------------------------------------------------------
module rx_pack_fifo
  import rx_pack_fifo_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int FWFT  = 1
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          flush_i,
  input  logic                          byte_valid_i,
  input  logic [BYTE_W-1:0]             byte_data_i,
  input  logic                          byte_last_i,
  output logic                          byte_ready_o,
  input  logic                          rd_en_i,
  output logic [WIDTH-1:0]              rd_data_o,
  output logic                          rd_valid_o,
  output logic                          empty_o,
  output logic                          full_o,
  output logic [$clog2(DEPTH):0]        level_o,
  output logic [pack_cnt_w(WIDTH)-1:0]  pack_cnt_o,
  input  logic [$clog2(DEPTH):0]        watermark_i,
  output logic                          wm_o,
  output logic                          ovf_o,
  output logic                          udf_o,
  input  logic                          err_clr_i
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;

  logic             full, empty;
  logic             byte_acc, pop, push;
  logic             ovf_set, udf_set;
  logic [WIDTH-1:0] pack_word;

  assign full  = (level_q == FULL_LVL);
  assign empty = (level_q == '0);

  assign byte_ready_o = !full && !flush_i;
  assign byte_acc     = byte_valid_i && byte_ready_o;
  // Flush overrides a pop and also masks it from the underflow flag.
  assign pop          = rd_en_i && !empty && !flush_i;
  assign ovf_set      = byte_valid_i && !byte_ready_o && !flush_i;
  assign udf_set      = rd_en_i && empty && !flush_i;

  rx_byte_packer #(
    .WIDTH (WIDTH)
  ) u_packer (
    .clk         (clk),
    .resetn      (resetn),
    .flush_i     (flush_i),
    .byte_acc_i  (byte_acc),
    .byte_data_i (byte_data_i),
    .byte_last_i (byte_last_i),
    .word_o      (pack_word),
    .push_o      (push),
    .pack_cnt_o  (pack_cnt_o)
  );

  // push can only occur when not full and not flushing (byte_ready_o gates it),
  // so storage never overruns and flush never races a write.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   level_d = level_q + (AW+1)'(1);
        2'b01:   level_d = level_q - (AW+1)'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_comb begin
    ovf_d = ovf_q;
    udf_d = udf_q;
    if (err_clr_i) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
    if (ovf_set) ovf_d = 1'b1;
    if (udf_set) udf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= pack_word;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Masked while empty so the output is defined (zero) out of reset.
      assign rd_data_o  = empty ? '0 : mem_q[rd_ptr_q];
      assign rd_valid_o = !empty;
    end else begin : g_reg
      logic [WIDTH-1:0] rd_data_q;
      logic             rd_valid_q;

      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          rd_data_q  <= '0;
          rd_valid_q <= 1'b0;
        end else begin
          rd_valid_q <= pop;
          if (pop) begin
            rd_data_q <= mem_q[rd_ptr_q];
          end
        end
      end

      assign rd_data_o  = rd_data_q;
      assign rd_valid_o = rd_valid_q;
    end
  endgenerate

  assign empty_o = empty;
  assign full_o  = full;
  assign level_o = level_q;
  assign wm_o    = (level_q >= watermark_i);
  assign ovf_o   = ovf_q;
  assign udf_o   = udf_q;

endmodule
